if_stage: RTL and testbench

Instruction-fetch stage of the MiniMIPS32 pipeline: owns the PC, fetches instructions from the instruction SRAM port through a single-outstanding request/grant/response handshake, and presents `{pc, inst, exc_code, badvaddr}` to the IF/ID pipeline register. It applies branch redirects after the delay slot, flush redirects from the exception unit immediately, and detects misaligned fetch addresses. While no instruction is available, it stalls the pipeline through `stallreq_if`.

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and types for the MiniMIPS32 fetch stage
package if_stage_pkg;

    localparam int          EXC_CODE_WIDTH = 5;
    localparam logic [4:0]  EC_NONE        = 5'h10;
    localparam logic [4:0]  EC_ADEL        = 5'h04;

    localparam logic        STOP           = 1'b1;
    localparam logic        NO_STOP        = 1'b0;

    localparam logic [31:0] RESET_VECTOR   = 32'hBFC0_0000;

    // Fetch FSM: issue request, wait for data, hold for IF/ID, drop a stale response
    typedef enum logic [1:0] {
        IF_REQ     = 2'd0,
        IF_WAIT    = 2'd1,
        IF_HOLD    = 2'd2,
        IF_DISCARD = 2'd3
    } if_state_t;

    // Instruction fetches must be word aligned
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, single-outstanding SRAM fetch, delayed branch
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic                      cpu_clk_75M,
    input  logic                      cpu_rst_n,
    input  logic [5:0]                stall,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    input  logic                      id_branch_flag,
    input  logic [31:0]               id_branch_target,
    output logic                      iram_req,
    output logic [31:0]               iram_addr,
    input  logic                      iram_gnt,
    input  logic                      iram_rvalid,
    input  logic [31:0]               iram_rdata,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_inst,
    output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
    output logic [31:0]               exc_badvaddr_o,
    output logic                      stallreq_if
);

    if_state_t   r_state;
    if_state_t   w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_ibuf_inst;
    logic        r_ibuf_valid;
    logic        r_ibuf_exc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    logic        w_misaligned;
    logic        w_advance;
    logic [31:0] w_next_pc;
    logic        w_show;
    logic        w_unused_stall;

    // Only the PC-hold bit matters to this stage
    assign w_unused_stall = ^stall[5:1];

    assign w_misaligned = is_misaligned(r_pc);
    assign w_advance    = (r_state == IF_HOLD) && (stall[0] == NO_STOP) && !flush;

    // A branch arriving in the advance cycle redirects directly; otherwise a
    // previously latched branch wins over sequential flow
    assign w_next_pc = id_branch_flag ? id_branch_target :
                       r_pend_valid   ? r_pend_target    :
                                        r_pc + 32'd4;

    // State register
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= IF_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a flush in WAIT must still swallow the in-flight response
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            case (r_state)
                IF_WAIT:    w_next_state = iram_rvalid ? IF_REQ : IF_DISCARD;
                IF_DISCARD: w_next_state = iram_rvalid ? IF_REQ : IF_DISCARD;
                default:    w_next_state = IF_REQ;
            endcase
        end else begin
            case (r_state)
                IF_REQ: begin
                    if (w_misaligned) begin
                        w_next_state = IF_HOLD;
                    end else if (iram_gnt) begin
                        w_next_state = IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (iram_rvalid) begin
                        w_next_state = IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    if (stall[0] == NO_STOP) begin
                        w_next_state = IF_REQ;
                    end
                end
                IF_DISCARD: begin
                    if (iram_rvalid) begin
                        w_next_state = IF_REQ;
                    end
                end
                default: w_next_state = IF_REQ;
            endcase
        end
    end

    // Outputs: nothing is shown while the buffer is empty or a flush is in progress
    always_comb begin
        w_show         = r_ibuf_valid && !flush;
        iram_req       = cpu_rst_n && (r_state == IF_REQ) && !w_misaligned && !flush;
        iram_addr      = r_pc;
        if_pc          = r_pc;
        if_inst        = w_show ? r_ibuf_inst : 32'd0;
        exc_code_o     = (w_show && r_ibuf_exc) ? EC_ADEL : EC_NONE;
        exc_badvaddr_o = (w_show && r_ibuf_exc) ? r_pc : 32'd0;
        stallreq_if    = !r_ibuf_valid;
    end

    // PC and instruction buffer
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_pc         <= RESET_PC;
            r_ibuf_inst  <= 32'd0;
            r_ibuf_valid <= 1'b0;
            r_ibuf_exc   <= 1'b0;
        end else if (flush) begin
            r_pc         <= flush_pc;
            r_ibuf_inst  <= 32'd0;
            r_ibuf_valid <= 1'b0;
            r_ibuf_exc   <= 1'b0;
        end else begin
            case (r_state)
                IF_REQ: begin
                    if (w_misaligned) begin
                        r_ibuf_inst  <= 32'd0;
                        r_ibuf_valid <= 1'b1;
                        r_ibuf_exc   <= 1'b1;
                    end
                end
                IF_WAIT: begin
                    if (iram_rvalid) begin
                        r_ibuf_inst  <= iram_rdata;
                        r_ibuf_valid <= 1'b1;
                        r_ibuf_exc   <= 1'b0;
                    end
                end
                IF_HOLD: begin
                    if (w_advance) begin
                        r_pc         <= w_next_pc;
                        r_ibuf_valid <= 1'b0;
                        r_ibuf_exc   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pending branch: latched until the delay slot advances
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (flush || w_advance) begin
            r_pend_valid  <= 1'b0;
        end else if (id_branch_flag) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= id_branch_target;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;
    import if_stage_pkg::*;

    logic                      clk;
    logic                      cpu_rst_n;
    logic [5:0]                stall;
    logic                      flush;
    logic [31:0]               flush_pc;
    logic                      id_branch_flag;
    logic [31:0]               id_branch_target;
    logic                      iram_req;
    logic [31:0]               iram_addr;
    logic                      iram_gnt;
    logic                      iram_rvalid;
    logic [31:0]               iram_rdata;
    logic [31:0]               if_pc;
    logic [31:0]               if_inst;
    logic [EXC_CODE_WIDTH-1:0] exc_code_o;
    logic [31:0]               exc_badvaddr_o;
    logic                      stallreq_if;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  exc;
        logic [31:0] bad;
    } pres_t;

    logic [31:0] exp_addr[$];
    pres_t       exp_pres[$];

    int n_checks = 0;
    int n_fail   = 0;

    int gnt_delay = 1;
    int rv_extra  = 0;

    if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .cpu_clk_75M      (clk),
        .cpu_rst_n        (cpu_rst_n),
        .stall            (stall),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .id_branch_flag   (id_branch_flag),
        .id_branch_target (id_branch_target),
        .iram_req         (iram_req),
        .iram_addr        (iram_addr),
        .iram_gnt         (iram_gnt),
        .iram_rvalid      (iram_rvalid),
        .iram_rdata       (iram_rdata),
        .if_pc            (if_pc),
        .if_inst          (if_inst),
        .exc_code_o       (exc_code_o),
        .exc_badvaddr_o   (exc_badvaddr_o),
        .stallreq_if      (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pres(input logic [31:0] pc, input logic [31:0] inst,
                             input logic [4:0] exc, input logic [31:0] bad);
        pres_t p;
        p.pc = pc; p.inst = inst; p.exc = exc; p.bad = bad;
        exp_pres.push_back(p);
    endtask

    task automatic wait_gnt(input logic [31:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (iram_req && iram_gnt && iram_addr == a) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_gnt_timeout", {31'd0, found}, 32'd1);
    endtask

    // Memory model: grant after gnt_delay request cycles, data 1+rv_extra cycles later
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'hBFC0_0000) r = 32'h2408_0001;
        else                    r = 32'h2400_0000 | {16'd0, a[15:0]};
        return r;
    endfunction

    initial begin
        int          wait_cnt;
        int          rv_cnt;
        logic [31:0] rv_addr;
        wait_cnt    = 0;
        rv_cnt      = 0;
        rv_addr     = 32'd0;
        iram_gnt    = 1'b0;
        iram_rvalid = 1'b0;
        iram_rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            iram_gnt    = 1'b0;
            iram_rvalid = 1'b0;
            if (!cpu_rst_n) begin
                wait_cnt = 0;
                rv_cnt   = 0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        iram_rvalid = 1'b1;
                        iram_rdata  = inst_of(rv_addr);
                    end
                end
                if (iram_req) begin
                    if (wait_cnt >= gnt_delay) begin
                        iram_gnt = 1'b1;
                        rv_addr  = iram_addr;
                        rv_cnt   = 1 + rv_extra;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // Monitor: compares every grant and every new presentation against the queues
    initial begin
        logic  prev_stallreq;
        pres_t e;
        prev_stallreq = 1'b1;
        forever begin
            @(negedge clk);
            if (!cpu_rst_n) begin
                prev_stallreq = 1'b1;
            end else begin
                if (iram_req && iram_gnt) begin
                    if (exp_addr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL grant_unexpected: got addr %h expected no request", iram_addr);
                    end else begin
                        chk("grant_addr", iram_addr, exp_addr.pop_front());
                    end
                end
                if (!stallreq_if && prev_stallreq && !flush) begin
                    if (exp_pres.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pres_unexpected: got pc %h inst %h expected nothing", if_pc, if_inst);
                    end else begin
                        e = exp_pres.pop_front();
                        chk("pres_pc",   if_pc,                  e.pc);
                        chk("pres_inst", if_inst,                e.inst);
                        chk("pres_exc",  {27'd0, exc_code_o},    {27'd0, e.exc});
                        chk("pres_bad",  exc_badvaddr_o,         e.bad);
                    end
                end
                prev_stallreq = stallreq_if;
            end
        end
    end

    initial begin
        cpu_rst_n        = 1'b0;
        stall            = 6'd0;
        flush            = 1'b0;
        flush_pc         = 32'd0;
        id_branch_flag   = 1'b0;
        id_branch_target = 32'd0;

        foreach (exp_addr[i]) exp_addr.delete(i);
        exp_addr.push_back(32'hBFC0_0000);
        exp_addr.push_back(32'hBFC0_0004);
        exp_addr.push_back(32'hBFC0_0008);
        exp_addr.push_back(32'hBFC0_0100);
        exp_addr.push_back(32'hBFC0_0104);
        exp_addr.push_back(32'hBFC0_0200);
        exp_addr.push_back(32'hBFC0_0380);
        exp_addr.push_back(32'hBFC0_0384);
        exp_addr.push_back(32'hBFC0_0388);
        exp_addr.push_back(32'hBFC0_0400);

        push_pres(32'hBFC0_0000, 32'h2408_0001, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0004, 32'h2400_0004, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0008, 32'h2400_0008, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0100, 32'h2400_0100, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0104, 32'h2400_0104, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0102, 32'd0,         EC_ADEL, 32'hBFC0_0102);
        push_pres(32'hBFC0_0380, 32'h2400_0380, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0384, 32'h2400_0384, EC_NONE, 32'd0);
        push_pres(32'hBFC0_0400, 32'h2400_0400, EC_NONE, 32'd0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",      {31'd0, iram_req},    32'd0);
        chk("rst_inst",     if_inst,              32'd0);
        chk("rst_exc",      {27'd0, exc_code_o},  {27'd0, EC_NONE});
        chk("rst_bad",      exc_badvaddr_o,       32'd0);
        chk("rst_pc",       if_pc,                32'hBFC0_0000);
        chk("rst_stallreq", {31'd0, stallreq_if}, 32'd1);
        tick();
        cpu_rst_n = 1'b1;

        // First fetch with one-cycle grant delay, then full speed
        wait_gnt(32'hBFC0_0000);
        gnt_delay = 0;

        // Delayed branch taken while fetching the delay slot
        wait_gnt(32'hBFC0_0008);
        tick();
        id_branch_flag   = 1'b1;
        id_branch_target = 32'hBFC0_0100;
        tick();
        id_branch_flag   = 1'b0;

        // Stall hold with a misaligned branch latched during the hold
        wait_gnt(32'hBFC0_0104);
        tick();
        stall[0] = STOP;
        tick();
        id_branch_flag   = 1'b1;
        id_branch_target = 32'hBFC0_0102;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_pc",       if_pc,                32'hBFC0_0104);
            chk("hold_inst",     if_inst,              32'h2400_0104);
            chk("hold_req",      {31'd0, iram_req},    32'd0);
            chk("hold_stallreq", {31'd0, stallreq_if}, 32'd0);
            tick();
            id_branch_flag = 1'b0;
        end
        stall[0] = NO_STOP;
        tick();
        @(negedge clk);
        chk("misal_req", {31'd0, iram_req}, 32'd0);
        chk("misal_pc",  if_pc,             32'hBFC0_0102);
        tick();
        // Branch in the same cycle as the advance redirects immediately
        id_branch_flag   = 1'b1;
        id_branch_target = 32'hBFC0_0200;
        rv_extra         = 2;
        tick();
        id_branch_flag   = 1'b0;

        // Flush while waiting for data: the late response must be dropped
        wait_gnt(32'hBFC0_0200);
        tick();
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        rv_extra = 0;
        @(negedge clk);
        chk("flush_wait_inst", if_inst,           32'd0);
        chk("flush_wait_req",  {31'd0, iram_req}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("discard_req", {31'd0, iram_req}, 32'd0);

        // Slow grant: request and address stay put
        wait_gnt(32'hBFC0_0380);
        gnt_delay = 4;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (iram_req) break;
        end
        for (int i = 0; i < 4; i++) begin
            chk("slow_req",      {31'd0, iram_req},    32'd1);
            chk("slow_addr",     iram_addr,            32'hBFC0_0384);
            chk("slow_gnt",      {31'd0, iram_gnt},    32'd0);
            chk("slow_stallreq", {31'd0, stallreq_if}, 32'd1);
            @(negedge clk);
        end
        gnt_delay = 0;

        // Flush while an instruction is held: nop shown in the flush cycle
        wait_gnt(32'hBFC0_0388);
        tick();
        stall[0] = STOP;
        tick();
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0400;
        @(negedge clk);
        chk("flush_hold_inst", if_inst,             32'd0);
        chk("flush_hold_exc",  {27'd0, exc_code_o}, {27'd0, EC_NONE});
        chk("flush_hold_bad",  exc_badvaddr_o,      32'd0);
        tick();
        flush = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_pres.size() == 0) break;
        end
        chk("pres_queue_empty", 32'(exp_pres.size()), 32'd0);
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
